// File: rtl/pingpong_sequencer_if.sv
// Host-side run-control bundle for pingpong_sequencer: request fields plus status.
interface pingpong_sequencer_if #(
    parameter int unsigned BOUNCE_W = 8
);
    logic                start;
    logic signed [31:0]  step_in;
    logic [BOUNCE_W-1:0] bounce_target;
    logic                busy;
    logic                done;
    logic                err;
    logic                dir;
    logic [BOUNCE_W-1:0] bounce_count;

    modport master (
        output start, step_in, bounce_target,
        input  busy, done, err, dir, bounce_count
    );

    modport slave (
        input  start, step_in, bounce_target,
        output busy, done, err, dir, bounce_count
    );
endinterface

// File: rtl/pingpong_sequencer.sv
// Run controller for one pingpong_module: clears it, drives the step, counts bounces, freezes on target.
// Optional RUN-state timeout enabled by defining PINGPONG_SEQ_TIMEOUT_EN.
module pingpong_sequencer #(
    parameter logic signed [31:0] MAX_THRESHOLD  = 32'sd100,
    parameter logic signed [31:0] MIN_THRESHOLD  = 32'sd0,
    parameter int unsigned        BOUNCE_W       = 8,
    parameter int unsigned        TIMEOUT_CYCLES = 1024
) (
    input  logic               clk,
    input  logic               rst,
    pingpong_sequencer_if.slave host,
    output logic               acc_rst,
    output logic signed [31:0] acc_step,
    input  logic signed [31:0] acc_value
);
    localparam int unsigned DATA_W = 32;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CLEAR = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]               state, state_next;
    logic signed [DATA_W-1:0] step_q, step_next;
    logic [BOUNCE_W-1:0]      target_q, target_next;
    logic [BOUNCE_W-1:0]      bounce_q, bounce_next;
    logic                     dir_q, dir_next;
    logic                     err_q, err_next;
    logic                     busy_q, done_q;
    logic signed [DATA_W-1:0] acc_step_q;
    logic                     bounce_ev;
    logic                     target_hit;
    logic                     timeout_hit;

    // Bounce event mirrors the datapath's own flip condition.
    assign bounce_ev  = (!dir_q && (acc_value >= MAX_THRESHOLD)) ||
                        ( dir_q && (acc_value <= MIN_THRESHOLD));
    assign target_hit = bounce_ev && ((bounce_q + BOUNCE_W'(1)) == target_q);

`ifdef PINGPONG_SEQ_TIMEOUT_EN
    logic [DATA_W-1:0] cyc_q;

    assign timeout_hit = (state == S_RUN) && (cyc_q == DATA_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_q <= '0;
        end else if (state == S_CLEAR) begin
            cyc_q <= '0;
        end else if (state == S_RUN) begin
            cyc_q <= cyc_q + DATA_W'(1);
        end
    end
`else
    logic unused_timeout;

    assign timeout_hit    = 1'b0;
    assign unused_timeout = ^DATA_W'(TIMEOUT_CYCLES);
`endif

    // Next-state and next-register values.
    always_comb begin
        state_next  = state;
        step_next   = step_q;
        target_next = target_q;
        bounce_next = bounce_q;
        dir_next    = dir_q;
        err_next    = err_q;
        case (state)
            S_IDLE: begin
                if (host.start) begin
                    step_next   = host.step_in;
                    target_next = host.bounce_target;
                    err_next    = 1'b0;
                    if (host.step_in <= 32'sd0) begin
                        state_next = S_DONE;
                        err_next   = 1'b1;
                    end else if (host.bounce_target == '0) begin
                        state_next = S_DONE;
                    end else begin
                        state_next = S_CLEAR;
                    end
                end
            end
            S_CLEAR: begin
                dir_next    = 1'b0;
                bounce_next = '0;
                state_next  = S_RUN;
            end
            S_RUN: begin
                if (bounce_ev) begin
                    dir_next    = ~dir_q;
                    bounce_next = bounce_q + BOUNCE_W'(1);
                end
                if (target_hit) begin
                    state_next = S_DONE;
                end else if (timeout_hit) begin
                    state_next = S_DONE;
                    err_next   = 1'b1;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            step_q     <= '0;
            target_q   <= '0;
            bounce_q   <= '0;
            dir_q      <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            acc_step_q <= '0;
        end else begin
            state      <= state_next;
            step_q     <= step_next;
            target_q   <= target_next;
            bounce_q   <= bounce_next;
            dir_q      <= dir_next;
            err_q      <= err_next;
            busy_q     <= (state_next == S_CLEAR) || (state_next == S_RUN);
            done_q     <= (state_next == S_DONE);
            acc_step_q <= (state_next == S_RUN) ? step_next : '0;
        end
    end

    assign acc_rst           = rst || (state == S_CLEAR);
    assign acc_step          = acc_step_q;
    assign host.busy         = busy_q;
    assign host.done         = done_q;
    assign host.err          = err_q;
    assign host.dir          = dir_q;
    assign host.bounce_count = bounce_q;
endmodule

// File: doc/pingpong_sequencer.md
# pingpong_sequencer

Run controller for the `pingpong_module` bouncing accumulator.
- Accepts a run request carrying a step value and a bounce target.
- Clears the accumulator, drives the step, and tracks the accumulator's up/down direction by mirroring its threshold rules.
- Counts bounces and freezes the accumulator (step forced to 0) once the target is reached, then reports completion.
- Sits between a host/register interface and one `pingpong_module` instance.

## Interface
- `MAX_THRESHOLD`, 100: upper bounce threshold; must equal the datapath's value.
- `MIN_THRESHOLD`, 0: lower bounce threshold; must equal the datapath's value.
- `BOUNCE_W`, 8: width of the bounce target and bounce counter.
- `TIMEOUT_CYCLES`, 1024: RUN-state cycle limit; used only with the timeout feature (see Configuration).

Ports:
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: run request; sampled only in IDLE.
- `step_in` in 32 signed: step value; latched on an accepted `start`.
- `bounce_target` in BOUNCE_W: number of bounces to run; latched on an accepted `start`.
- `busy` out 1: high in CLEAR and RUN.
- `done` out 1: one-cycle pulse at the end of a run.
- `err` out 1: qualifies `done`; holds its value until the next accepted `start`.
- `dir` out 1: 0 = counting up, 1 = counting down.
- `bounce_count` out BOUNCE_W: bounces completed in the current or last run.
- `acc_rst` out 1: drives the datapath `rst`.
- `acc_step` out 32 signed: drives the datapath `input_number`.
- `acc_value` in 32 signed: from the datapath `curr_reg_value`.

## Operation
States: IDLE, CLEAR, RUN, DONE.

- **IDLE**
  - `acc_step`=0, which holds the datapath value.
  - When `start`=1:
    - latch `step_q`←`step_in`, `target_q`←`bounce_target`, `err`←0;
    - if `step_in`≤0, go to DONE with `err`=1 (rejected);
    - else if `bounce_target`=0, go to DONE with `err`=0 and no datapath activity;
    - else go to CLEAR.
- **CLEAR** (exactly 1 cycle)
  - `acc_rst`=1, `acc_step`=0.
  - `dir`←0, `bounce_count`←0; go to RUN.
- **RUN**
  - `acc_step`=`step_q`.
  - Bounce event: (`dir`=0 and `acc_value`≥MAX_THRESHOLD) or (`dir`=1 and `acc_value`≤MIN_THRESHOLD).
  - On a bounce event: toggle `dir`, increment `bounce_count`. This happens on the same edge the datapath flips its own state.
  - If a bounce event occurs and `bounce_count`+1 = `target_q`, go to DONE.
- **DONE** (exactly 1 cycle)
  - `done`=1, `acc_step`=0; go to IDLE.
  - The final datapath value is frozen because the step is 0.

Other rules:
- `acc_rst` = `rst` OR (state=CLEAR), combinational.
- Threshold comparisons are signed, 32-bit.
- `bounce_count` increments without saturation. It cannot exceed `target_q`.
- `start` outside IDLE is ignored, including in DONE.
- Reset mid-run: the block returns to IDLE in the next cycle and the datapath is cleared via `acc_rst`.

## Timing
- Reset values: state IDLE, `busy` 0, `done` 0, `err` 0, `dir` 0, `bounce_count` 0, `acc_step` 0, `acc_rst` 1 while `rst`=1.
- Accepted `start` at edge N:
  - CLEAR during cycle N+1;
  - RUN from cycle N+2 (`acc_value`=0);
  - first added value visible at N+3.
- Latency from the final bounce detection to the `done` pulse: 1 cycle.
- Rejected or zero-target start: `done` in the cycle after `start`, with `busy` never asserted.
- `done` and `busy` are never high in the same cycle.

## Configuration
- `PINGPONG_SEQ_TIMEOUT_EN` defined:
  - a 32-bit cycle counter clears on CLEAR and increments in RUN;
  - if it reaches TIMEOUT_CYCLES before the target is met, go to DONE with `err`=1;
  - `bounce_count` keeps the partial count.
- Not defined: no counter or timeout logic; RUN ends only on reaching the target or on `rst`.

## Test plan
- `rst` held 3 cycles → all outputs at reset values, `acc_rst`=1; then `rst`=0 → `acc_rst`=0, `busy`=0.
- `step_in`=25, `bounce_target`=1 → `acc_value` 0,25,50,75,100; bounce detected at 100; `done` one cycle later; `err`=0, `bounce_count`=1, `dir`=1; `acc_value` holds 100 for 10 idle cycles.
- `step_in`=30, `bounce_target`=2 → up 30..120, down 90,60,30,0; `done` with `bounce_count`=2, `dir`=0, final `acc_value`=0.
- `step_in`=−5 → `done`=1, `err`=1 in the next cycle; `busy` never high; `acc_rst` never pulsed.
- `start` re-asserted during RUN and during DONE → ignored; the first run's counts are unaffected. `rst` pulsed mid-RUN → IDLE, `acc_value`=0.
- With `PINGPONG_SEQ_TIMEOUT_EN`, TIMEOUT_CYCLES=20, `step_in`=1, `bounce_target`=1 → `done`, `err`=1, `bounce_count`=0 after 20 RUN cycles. Without the macro, the same stimulus completes normally at `acc_value`=100.
